mox_fetch: RTL

Instruction fetch stage for the mox125 pipeline, sitting directly upstream of the direct-mapped instruction cache and downstream-feeding the decoder.
- Holds the fetch PC and drives it as the cache lookup address.
- Consumes the cache's combinational hit/instruction/immediate outputs and predecodes the Moxie instruction length (16/32/48 bits).
- Pushes complete {pc, inst, imm, len} entries into a small queue drained by decode with a valid/ready handshake.
- Accepts flush/redirect from execute.

---
 rtl/mox_pkg.sv | 58 +++++
 rtl/mox_fetch_queue.sv | 73 +++++++
 rtl/mox_fetch.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mox_pkg.sv
// Shared definitions for the mox125 fetch stage: Moxie form-1 opcodes,
// instruction-length predecode, fetch FSM states and the queued entry type.
package mox_pkg;

    // Form-1 opcodes (inst[15:8]) that carry a 32-bit immediate
    localparam logic [7:0] OP_LDI_L = 8'h01;
    localparam logic [7:0] OP_JSRA  = 8'h03;
    localparam logic [7:0] OP_LDA_L = 8'h08;
    localparam logic [7:0] OP_STA_L = 8'h09;
    localparam logic [7:0] OP_JMPA  = 8'h1a;
    localparam logic [7:0] OP_LDI_B = 8'h1b;
    localparam logic [7:0] OP_LDA_B = 8'h1d;
    localparam logic [7:0] OP_STA_B = 8'h1f;
    localparam logic [7:0] OP_LDI_S = 8'h20;
    localparam logic [7:0] OP_LDA_S = 8'h22;
    localparam logic [7:0] OP_STA_S = 8'h24;
    localparam logic [7:0] OP_SWI   = 8'h30;

    // Form-1 opcodes that carry a 16-bit offset
    localparam logic [7:0] OP_LDO_L = 8'h0c;
    localparam logic [7:0] OP_STO_L = 8'h0d;
    localparam logic [7:0] OP_LDO_B = 8'h36;
    localparam logic [7:0] OP_STO_B = 8'h37;
    localparam logic [7:0] OP_LDO_S = 8'h38;
    localparam logic [7:0] OP_STO_S = 8'h39;

    typedef enum logic [1:0] {
        FS_RUN  = 2'd0,
        FS_MISS = 2'd1,
        FS_FULL = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [15:0] inst;
        logic [31:0] imm;
        logic [1:0]  len;
    } fetch_entry_t;

    // Instruction length in halfwords; form 2/3 (inst[15] set) are always 1.
    function automatic logic [1:0] mox_inst_len(input logic [15:0] inst);
        logic [1:0] len;
        len = 2'd1;
        if (!inst[15]) begin
            case (inst[15:8])
                OP_LDI_L, OP_JSRA, OP_LDA_L, OP_STA_L, OP_JMPA, OP_LDI_B,
                OP_LDA_B, OP_STA_B, OP_LDI_S, OP_LDA_S, OP_STA_S, OP_SWI:
                    len = 2'd3;
                OP_LDO_L, OP_STO_L, OP_LDO_B, OP_STO_B, OP_LDO_S, OP_STO_S:
                    len = 2'd2;
                default:
                    len = 2'd1;
            endcase
        end
        return len;
    endfunction

endpackage

// File: rtl/mox_fetch_queue.sv
// Circular FIFO of fetch entries between fetch and decode; synchronous
// clear discards all entries. Depth must be a power of two, at least 2.
module mox_fetch_queue
    import mox_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clear_i,
    input  logic                      push_i,
    input  fetch_entry_t              push_data_i,
    input  logic                      pop_i,
    output fetch_entry_t              head_o,
    output logic                      valid_o,
    output logic [$clog2(QDEPTH):0]   count_o
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(QDEPTH);

    fetch_entry_t  mem_q [QDEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign valid_o = (count_q != '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    assign do_push = push_i && !clear_i && (count_q != CNT_MAX);
    assign do_pop  = pop_i && !clear_i && valid_o;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
            else if (do_pop && !do_push) count_d = count_q - CNT_ONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; an entry is only visible once count covers it.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/mox_fetch.sv
// mox125 instruction fetch: PC, cache lookup, length predecode and decode queue.
// Optional miss-stall counter on stall_cnt_o when MOX_FETCH_STATS_EN is defined.
module mox_fetch
    import mox_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_1000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] ic_adr_o,
    output logic        ic_stb_o,
    input  logic        ic_hit_i,
    input  logic [15:0] ic_inst_i,
    input  logic [31:0] ic_data_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [15:0] inst_o,
    output logic [31:0] imm_o,
    output logic [1:0]  len_o,
    output logic [31:0] pc_o
`ifdef MOX_FETCH_STATS_EN
    ,
    output logic [31:0] stall_cnt_o
`endif
);

    localparam int CW = $clog2(QDEPTH) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(QDEPTH);

    fetch_state_t  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic          push;
    logic          q_pop;
    logic          q_valid;
    logic          q_full;
    logic [CW-1:0] q_count;
    logic [1:0]    lkp_len;
    fetch_entry_t  lkp_entry;
    fetch_entry_t  q_head;
    fetch_entry_t  head;

    assign lkp_len = mox_inst_len(ic_inst_i);
    assign q_full  = (q_count == CNT_MAX);

    always_comb begin
        lkp_entry      = '0;
        lkp_entry.pc   = pc_q;
        lkp_entry.inst = ic_inst_i;
        lkp_entry.len  = lkp_len;
        case (lkp_len)
            2'd2:    lkp_entry.imm = {16'h0000, ic_data_i[31:16]};
            2'd3:    lkp_entry.imm = ic_data_i;
            default: lkp_entry.imm = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        case (state_q)
            FS_RUN: begin
                if (q_full) begin
                    state_d = FS_FULL;
                end else if (ic_hit_i) begin
                    push = 1'b1;
                    pc_d = pc_q + {29'd0, lkp_len, 1'b0};
                end else begin
                    state_d = FS_MISS;
                end
            end
            FS_MISS: begin
                if (ic_hit_i) begin
                    if (q_full) begin
                        state_d = FS_FULL;
                    end else begin
                        push    = 1'b1;
                        pc_d    = pc_q + {29'd0, lkp_len, 1'b0};
                        state_d = FS_RUN;
                    end
                end
            end
            FS_FULL: begin
                if (!q_full) state_d = FS_RUN;
            end
            default: state_d = FS_RUN;
        endcase
        // A redirect overrides any lookup result in the same cycle
        if (flush_i) begin
            push    = 1'b0;
            pc_d    = flush_pc_i & 32'hFFFF_FFFE;
            state_d = FS_RUN;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FS_RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign ic_adr_o = pc_q;
    assign ic_stb_o = !rst_i && (state_q != FS_FULL);
    assign q_pop    = ready_i && q_valid && !flush_i;

    mox_fetch_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (flush_i),
        .push_i      (push),
        .push_data_i (lkp_entry),
        .pop_i       (q_pop),
        .head_o      (q_head),
        .valid_o     (q_valid),
        .count_o     (q_count)
    );

    // Unwritten queue slots never reach decode: an empty queue presents zeros
    assign head    = q_valid ? q_head : '0;
    assign valid_o = q_valid;
    assign inst_o  = head.inst;
    assign imm_o   = head.imm;
    assign len_o   = head.len;
    assign pc_o    = head.pc;

`ifdef MOX_FETCH_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == FS_MISS && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
